mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
- REQ-001 SHALL have parameter NUM_PORTS, default 2, meaning number of requester ports (legal 2..8).
- REQ-002 SHALL have parameter ADDR_WIDTH, default 32, meaning address width.
- REQ-003 SHALL have parameter DATA_WIDTH, default 32, meaning data width (multiple of 8).
- REQ-004 SHALL have parameter ARB_MODE, default 1, meaning 0 = fixed priority with port 0 highest, 1 = round-robin.
- REQ-005 SHALL have port clk, input, 1, meaning the single clock.
- REQ-006 SHALL have port rst, input, 1, meaning reset; one clock, reset synchronous and active-low (rst=0 resets on rising clk edge).
- REQ-007 SHALL have port port_read, input, NUM_PORTS, meaning per-port read request.
- REQ-008 SHALL have port port_write, input, NUM_PORTS, meaning per-port write request.
- REQ-009 SHALL have port port_address, input, NUM_PORTS*ADDR_WIDTH, meaning per-port address, packed with port 0 in the LSBs.
- REQ-010 SHALL have port port_wdata, input, NUM_PORTS*DATA_WIDTH, meaning per-port write data, packed.
- REQ-011 SHALL have port port_byte_enable, input, NUM_PORTS*DATA_WIDTH/8, meaning per-port byte enables, packed.
- REQ-012 SHALL have port port_resp, output, NUM_PORTS, meaning per-port completion strobe.
- REQ-013 SHALL have port port_rdata, output, DATA_WIDTH, meaning read data shared by all ports, qualified by port_resp.
- REQ-014 SHALL have ports mem_read/mem_write (output, 1), mem_address (output, ADDR_WIDTH), mem_wdata (output, DATA_WIDTH), mem_byte_enable (output, DATA_WIDTH/8), mem_resp (input, 1), mem_rdata (input, DATA_WIDTH), meaning the downstream memory port.
- REQ-015 SHALL have ports busy (output, 1) and grant_id (output, clog2(NUM_PORTS)), meaning a transaction is in flight and the owning port.

Function
- REQ-016 SHALL implement FSM states IDLE and BUSY.
- REQ-017 In IDLE, when any port has port_read or port_write high, SHALL select one port per ARB_MODE, register its address, wdata, byte_enable and direction, and enter BUSY on the next edge.
- REQ-018 In round-robin mode, SHALL search from the port after the last granted port, wrapping from NUM_PORTS-1 to 0; the last-granted pointer resets to NUM_PORTS-1 so that port 0 wins first.
- REQ-019 In BUSY, SHALL drive mem_read or mem_write together with mem_address, mem_wdata and mem_byte_enable from the registered request; these outputs are stable for the whole transaction.
- REQ-020 In IDLE, SHALL drive mem_read, mem_write and mem_byte_enable to 0.
- REQ-021 When mem_resp=1 in BUSY, SHALL pulse port_resp[grant_id] for that same cycle, pass mem_rdata combinationally to port_rdata, and return to IDLE on the next edge.
- REQ-022 Minimum latency from request to mem_read/mem_write SHALL be 1 cycle; a new grant SHALL NOT occur in the cycle port_resp is asserted.
- REQ-023 If port_read and port_write are both high on one port at grant, SHALL perform a write.
- REQ-024 Requester changes made while BUSY SHALL NOT alter the in-flight transaction.
- REQ-025 SHALL ignore mem_resp while in IDLE.
- REQ-026 port_resp SHALL be one-hot or zero in every cycle.

Reset
- REQ-027 With rst=0 at a clock edge, SHALL enter IDLE and set busy=0, grant_id=0, port_resp=0, mem_read=0, mem_write=0, round-robin pointer=NUM_PORTS-1, and clear the registered request.
- REQ-028 A reset during BUSY SHALL abort the transaction with no port_resp.

Configuration
- REQ-029 Macro MEM_ARBITER_TIMEOUT_EN, when defined, SHALL add parameter TIMEOUT_CYCLES (default 255), a BUSY-cycle counter, and an output port_err (NUM_PORTS); after TIMEOUT_CYCLES BUSY cycles without mem_resp, SHALL pulse port_err[grant_id] for 1 cycle, deassert mem_read/mem_write, and return to IDLE.
- REQ-030 Without MEM_ARBITER_TIMEOUT_EN, the port_err port and the counter SHALL be absent, and BUSY SHALL persist until mem_resp.

Verification
- REQ-031 Single read: port1 reads 0x0000_1000, mem_resp after 3 cycles with mem_rdata=0xDEADBEEF -> port_resp=2'b10 for 1 cycle, port_rdata=0xDEADBEEF.
- REQ-032 Contention, ARB_MODE=1: ports 0 and 1 request continuously -> grants alternate 0,1,0,1; ARB_MODE=0 -> port 0 always wins.
- REQ-033 Write on port0: address 0x40, wdata 0x12345678, byte_enable 4'b0011, with inputs changed while BUSY -> mem_* keep the original values until mem_resp.
- REQ-034 Reset mid-transaction: rst=0 during BUSY -> next cycle busy=0, mem_read=0, no port_resp; the next grant goes to port 0.
- REQ-035 With MEM_ARBITER_TIMEOUT_EN and TIMEOUT_CYCLES=4, mem_resp never asserted -> port_err[grant_id] pulses after 4 BUSY cycles, then IDLE.
- REQ-036 Read and write both high on port 2 (NUM_PORTS=4) -> mem_write=1, mem_read=0.

Source files
------------

// File: rtl/mem_arbiter.sv
// N-port request arbiter in front of a single memory port; one transaction in flight at a time.
// Optional per-transaction timeout enabled by defining MEM_ARBITER_TIMEOUT_EN.
module mem_arbiter #(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ARB_MODE   = 1
`ifdef MEM_ARBITER_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 255
`endif
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_PORTS-1:0]              port_read,
  input  logic [NUM_PORTS-1:0]              port_write,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]   port_address,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]   port_wdata,
  input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] port_byte_enable,
  output logic [NUM_PORTS-1:0]              port_resp,
  output logic [DATA_WIDTH-1:0]             port_rdata,
  output logic                              mem_read,
  output logic                              mem_write,
  output logic [ADDR_WIDTH-1:0]             mem_address,
  output logic [DATA_WIDTH-1:0]             mem_wdata,
  output logic [DATA_WIDTH/8-1:0]           mem_byte_enable,
  input  logic                              mem_resp,
  input  logic [DATA_WIDTH-1:0]             mem_rdata,
  output logic                              busy,
  output logic [$clog2(NUM_PORTS)-1:0]      grant_id
`ifdef MEM_ARBITER_TIMEOUT_EN
  , output logic [NUM_PORTS-1:0]            port_err
`endif
);

  localparam int GW = $clog2(NUM_PORTS);
  localparam int BW = DATA_WIDTH / 8;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                   r_state;
  logic [GW-1:0]            r_grant;
  logic [GW-1:0]            r_last;
  logic [ADDR_WIDTH-1:0]    r_addr;
  logic [DATA_WIDTH-1:0]    r_wdata;
  logic [BW-1:0]            r_be;
  logic                     r_mem_rd;
  logic                     r_mem_wr;

  logic [NUM_PORTS-1:0]                 w_req;
  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] w_addr;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] w_wdata;
  logic [NUM_PORTS-1:0][BW-1:0]         w_be;
  logic [NUM_PORTS-1:0]                 w_onehot;
  logic [GW-1:0]                        w_sel;
  logic                                 w_hit;
  int                                   w_best;
  int                                   w_dist;

  assign w_req    = port_read | port_write;
  assign w_addr   = port_address;
  assign w_wdata  = port_wdata;
  assign w_be     = port_byte_enable;
  assign w_onehot = NUM_PORTS'(1) << r_grant;

  // Round-robin: each requester's distance past the last grant; smallest distance wins.
  always_comb begin
    w_sel  = '0;
    w_hit  = 1'b0;
    w_best = 0;
    w_dist = 0;
    if (ARB_MODE == 0) begin
      for (int i = NUM_PORTS - 1; i >= 0; i--)
        if (w_req[i]) w_sel = GW'(i);
    end else begin
      for (int j = 0; j < NUM_PORTS; j++) begin
        w_dist = j - int'(r_last) - 1;
        if (w_dist < 0) w_dist = w_dist + NUM_PORTS;
        if (w_req[j] && (!w_hit || w_dist < w_best)) begin
          w_sel  = GW'(j);
          w_best = w_dist;
          w_hit  = 1'b1;
        end
      end
    end
  end

`ifdef MEM_ARBITER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0]        r_cnt;
  logic [NUM_PORTS-1:0] r_err;
  assign port_err = r_err;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_grant  <= '0;
      r_last   <= GW'(NUM_PORTS - 1);
      r_addr   <= '0;
      r_wdata  <= '0;
      r_be     <= '0;
      r_mem_rd <= 1'b0;
      r_mem_wr <= 1'b0;
`ifdef MEM_ARBITER_TIMEOUT_EN
      r_cnt    <= '0;
      r_err    <= '0;
`endif
    end else begin
`ifdef MEM_ARBITER_TIMEOUT_EN
      r_err <= '0;
`endif
      case (r_state)
        IDLE: begin
          if (|w_req) begin
            r_state  <= BUSY;
            r_grant  <= w_sel;
            r_last   <= w_sel;
            r_addr   <= w_addr[w_sel];
            r_wdata  <= w_wdata[w_sel];
            r_be     <= w_be[w_sel];
            // Read+write together on one port resolves to a write.
            r_mem_wr <= port_write[w_sel];
            r_mem_rd <= ~port_write[w_sel];
`ifdef MEM_ARBITER_TIMEOUT_EN
            r_cnt    <= '0;
`endif
          end
        end
        BUSY: begin
          if (mem_resp) begin
            r_state  <= IDLE;
            r_mem_rd <= 1'b0;
            r_mem_wr <= 1'b0;
            r_be     <= '0;
          end
`ifdef MEM_ARBITER_TIMEOUT_EN
          else if (r_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            r_state  <= IDLE;
            r_mem_rd <= 1'b0;
            r_mem_wr <= 1'b0;
            r_be     <= '0;
            r_err    <= w_onehot;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
`endif
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy            = (r_state == BUSY);
  assign grant_id        = r_grant;
  assign mem_read        = r_mem_rd;
  assign mem_write       = r_mem_wr;
  assign mem_address     = r_addr;
  assign mem_wdata       = r_wdata;
  assign mem_byte_enable = r_be;
  assign port_resp       = (r_state == BUSY && mem_resp) ? w_onehot : '0;
  assign port_rdata      = mem_rdata;

endmodule
